accum_req_arbiter: RTL and testbench

//  Shares one add/sub accumulator datapath (WB-style valid/we/ready slave) between NREQ requesters.

---
 rtl/accum_req_arbiter_if.sv | 35 +++
 rtl/accum_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_accum_req_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_req_arbiter_if.sv
// Requester-side and datapath-side signals of the shared accumulator arbiter.
// master = the arbiter, slave = the environment (requesters plus datapath).
interface accum_req_arbiter_if #(
    parameter int BITS = 32,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] req_data;
    logic [NREQ-1:0]      req_nadd_sub;
    logic [NREQ-1:0]      req_use_prev;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic [BITS-1:0]      result;
    logic                 busy;
    logic                 dp_valid;
    logic                 dp_we;
    logic [BITS-1:0]      dp_wdata;
    logic                 dp_nadd_sub;
    logic                 dp_use_prev;
    logic                 dp_ready;
    logic [BITS-1:0]      dp_rdata;

    modport master (
        input  req, req_data, req_nadd_sub, req_use_prev, dp_ready, dp_rdata,
        output gnt, done, err, result, busy,
               dp_valid, dp_we, dp_wdata, dp_nadd_sub, dp_use_prev
    );

    modport slave (
        output req, req_data, req_nadd_sub, req_use_prev, dp_ready, dp_rdata,
        input  gnt, done, err, result, busy,
               dp_valid, dp_we, dp_wdata, dp_nadd_sub, dp_use_prev
    );
endinterface

// File: rtl/accum_req_arbiter.sv
// Round-robin arbiter sequencing shared add/sub accumulator transactions:
// operand write, one gap cycle, result read, then done or watchdog abort.
module accum_req_arbiter #(
    parameter int BITS    = 32,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    accum_req_arbiter_if.master bus
);
    // state | meaning
    // IDLE  | waiting for any req; next grant decided here
    // WR    | operand write, dp_valid held until dp_ready
    // GAP   | dead cycle so the datapath sees its ready drop
    // RD    | result read, dp_valid held until dp_ready
    // DONE  | done pulse to the granted requester
    // ABORT | err pulse after watchdog expiry
    typedef enum logic [2:0] {IDLE, WR, GAP, RD, DONE, ABORT} state_t;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          r_state, w_state;
    logic [NREQ-1:0] r_gnt, w_gnt, r_done, w_done, r_err, w_err;
    logic [BITS-1:0] r_result, w_result, r_wdata, w_wdata, w_opnd;
    logic            r_busy, w_busy, r_valid, w_valid, r_we, w_we;
    logic            r_nadd_sub, w_nadd_sub, r_use_prev, w_use_prev;
    logic [PW-1:0]   r_ptr, w_ptr, r_gidx, w_gidx, w_sel, w_cand, w_next_ptr;
    logic [PW:0]     w_idx;
    logic            w_found, w_expired;
    logic [WW-1:0]   r_wd, w_wd;

    // Search from ptr upward with an explicit wrap so any NREQ works.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(NREQ))
                w_idx = w_idx - (PW+1)'(NREQ);
            w_cand = w_idx[PW-1:0];
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_opnd = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_sel == PW'(i))
                w_opnd = bus.req_data[i*BITS +: BITS];
    end

    assign w_next_ptr = (r_gidx == PW'(NREQ-1)) ? '0 : r_gidx + PW'(1);
    assign w_expired  = (r_wd == WW'(TIMEOUT-1));

    always_comb begin
        w_state    = r_state;
        w_gnt      = r_gnt;
        w_done     = '0;
        w_err      = '0;
        w_result   = r_result;
        w_valid    = r_valid;
        w_we       = r_we;
        w_wdata    = r_wdata;
        w_nadd_sub = r_nadd_sub;
        w_use_prev = r_use_prev;
        w_ptr      = r_ptr;
        w_gidx     = r_gidx;
        w_wd       = r_wd;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gidx     = w_sel;
                    w_gnt      = NREQ'(1) << w_sel;
                    w_wdata    = w_opnd;
                    w_nadd_sub = bus.req_nadd_sub[w_sel];
                    w_use_prev = bus.req_use_prev[w_sel];
                    w_valid    = 1'b1;
                    w_we       = 1'b1;
                    w_wd       = '0;
                    w_state    = WR;
                end
            end
            WR, RD: begin
                if (bus.dp_ready) begin
                    w_valid = 1'b0;
                    if (r_state == WR) begin
                        w_state = GAP;
                    end else begin
                        w_result = bus.dp_rdata;
                        w_done   = NREQ'(1) << r_gidx;
                        w_gnt    = '0;
                        w_ptr    = w_next_ptr;
                        w_state  = DONE;
                    end
                end else if (w_expired) begin
                    w_valid = 1'b0;
                    w_err   = NREQ'(1) << r_gidx;
                    w_gnt   = '0;
                    w_ptr   = w_next_ptr;
                    w_state = ABORT;
                end else begin
                    w_wd = r_wd + WW'(1);
                end
            end
            GAP: begin
                w_valid = 1'b1;
                w_we    = 1'b0;
                w_wd    = '0;
                w_state = RD;
            end
            DONE, ABORT: w_state = IDLE;
            default:     w_state = IDLE;
        endcase
        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_nadd_sub <= 1'b0;
            r_use_prev <= 1'b0;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_wd       <= '0;
        end else begin
            r_state    <= w_state;
            r_gnt      <= w_gnt;
            r_done     <= w_done;
            r_err      <= w_err;
            r_result   <= w_result;
            r_busy     <= w_busy;
            r_valid    <= w_valid;
            r_we       <= w_we;
            r_wdata    <= w_wdata;
            r_nadd_sub <= w_nadd_sub;
            r_use_prev <= w_use_prev;
            r_ptr      <= w_ptr;
            r_gidx     <= w_gidx;
            r_wd       <= w_wd;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.result      = r_result;
    assign bus.busy        = r_busy;
    assign bus.dp_valid    = r_valid;
    assign bus.dp_we       = r_we;
    assign bus.dp_wdata    = r_wdata;
    assign bus.dp_nadd_sub = r_nadd_sub;
    assign bus.dp_use_prev = r_use_prev;
endmodule

// File: tb/tb_accum_req_arbiter.sv
// Scoreboard bench for accum_req_arbiter: a round-robin sequence predictor queues
// expected done/err pulses, a monitor pops and compares them as they appear.
module tb_accum_req_arbiter;
    localparam int BITS    = 32;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;
    localparam int NOACK   = 1000;

    typedef struct {
        int          id;
        bit          is_err;
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   bfm_delay = 1;
    bit   spur_en = 1'b1;

    exp_t        exp_q[$];
    int          m_ptr;
    logic [31:0] m_prev, m_last;

    int          rem[NREQ];
    int          opi[NREQ];
    bit          drop[NREQ];
    int          t_raise[NREQ];
    logic [31:0] op_data[NREQ][4];
    bit          op_ns[NREQ][4];
    bit          op_up[NREQ][4];

    accum_req_arbiter_if #(.BITS(BITS), .NREQ(NREQ)) bus();

    accum_req_arbiter #(.BITS(BITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .bus     (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        onehot = NREQ'(1) << i;
    endfunction

    function automatic bit any_rem();
        any_rem = 1'b0;
        for (int i = 0; i < NREQ; i++) if (rem[i] > 0) any_rem = 1'b1;
    endfunction

    function automatic logic [31:0] arith(input logic [31:0] d, input bit ns, input bit up,
                                          input logic [31:0] prev);
        logic [31:0] a, b;
        a = up ? prev : {16'h0, d[31:16]};
        b = up ? d    : {16'h0, d[15:0]};
        arith = ns ? a - b : a + b;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},      bus.gnt, 0);
        check({tag, "_done"},     bus.done, 0);
        check({tag, "_err"},      bus.err, 0);
        check({tag, "_result"},   bus.result, 0);
        check({tag, "_busy"},     bus.busy, 0);
        check({tag, "_dp_valid"}, bus.dp_valid, 0);
        check({tag, "_dp_we"},    bus.dp_we, 0);
        check({tag, "_dp_wdata"}, bus.dp_wdata, 0);
        check({tag, "_dp_ns"},    bus.dp_nadd_sub, 0);
        check({tag, "_dp_up"},    bus.dp_use_prev, 0);
    endtask

    task automatic clear_phase();
        for (int i = 0; i < NREQ; i++) begin
            rem[i]  = 0;
            opi[i]  = 0;
            drop[i] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                op_data[i][j] = $urandom;
                op_ns[i][j]   = 1'($urandom_range(0, 1));
                op_up[i][j]   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // Service order: rotate from the pointer to the next requester with work left.
    task automatic predict(input int lat0);
        int   r[NREQ];
        int   pick, k, j;
        bit   first;
        exp_t e;
        first = 1'b1;
        for (int i = 0; i < NREQ; i++) r[i] = rem[i];
        for (int t = 0; t < 64; t++) begin
            pick = -1;
            for (int s = 0; s < NREQ; s++) begin
                k = (m_ptr + s) % NREQ;
                if (pick < 0 && r[k] > 0) pick = k;
            end
            if (pick < 0) break;
            j        = rem[pick] - r[pick];
            e.id     = pick;
            e.lat    = first ? lat0 : -1;
            first    = 1'b0;
            if (bfm_delay >= TIMEOUT) begin
                e.is_err = 1'b1;
                e.res    = m_last;
            end else begin
                e.is_err = 1'b0;
                m_prev   = arith(op_data[pick][j], op_ns[pick][j], op_up[pick][j], m_prev);
                m_last   = m_prev;
                e.res    = m_prev;
            end
            exp_q.push_back(e);
            r[pick]--;
            m_ptr = (pick + 1) % NREQ;
        end
    endtask

    task automatic present(input int i);
        bus.req_data[i*BITS +: BITS] = op_data[i][opi[i]];
        bus.req_nadd_sub[i]          = op_ns[i][opi[i]];
        bus.req_use_prev[i]          = op_up[i][opi[i]];
        bus.req[i]                   = 1'b1;
        t_raise[i]                   = cyc;
    endtask

    task automatic run_phase(input int lat0);
        int budget;
        predict(lat0);
        @(negedge wb_clk_i);
        for (int i = 0; i < NREQ; i++) if (rem[i] > 0) present(i);
        budget = 0;
        while ((any_rem() || bus.busy) && budget < 3000) begin
            @(negedge wb_clk_i);
            budget++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.done[i] || bus.err[i]) begin
                    if (rem[i] > 0) rem[i]--;
                    opi[i]++;
                    if (rem[i] > 0) present(i);
                    else bus.req[i] = 1'b0;
                end
                if (drop[i] && bus.gnt[i] && bus.dp_we && bus.req[i]) bus.req[i] = 1'b0;
            end
        end
        if (budget >= 3000) check("phase_timeout", budget, 0);
        repeat (2) @(negedge wb_clk_i);
    endtask

    // Datapath model: acks bfm_delay cycles after valid, sprinkles ignored ready pulses.
    initial begin
        int          cnt;
        bit          spur, real_ack;
        logic [31:0] op, v, bfm_prev;
        bit          ns, up;
        cnt = 0; spur = 1'b0; op = '0; ns = 1'b0; up = 1'b0; bfm_prev = '0;
        bus.dp_ready = 1'b0;
        bus.dp_rdata = '0;
        forever begin
            @(negedge wb_clk_i);
            real_ack     = bus.dp_ready && !spur;
            bus.dp_ready = 1'b0;
            spur         = 1'b0;
            bus.dp_rdata = $urandom;
            if (bus.dp_valid && !real_ack) begin
                if (cnt >= bfm_delay) begin
                    cnt          = 0;
                    bus.dp_ready = 1'b1;
                    if (bus.dp_we) begin
                        op = bus.dp_wdata;
                        ns = bus.dp_nadd_sub;
                        up = bus.dp_use_prev;
                    end else begin
                        check("op_mode_stable", {bus.dp_nadd_sub, bus.dp_use_prev}, {ns, up});
                        v            = arith(op, ns, up, bfm_prev);
                        bfm_prev     = v;
                        bus.dp_rdata = v;
                    end
                end else begin
                    cnt++;
                end
            end else if (!bus.dp_valid) begin
                cnt = 0;
                if (spur_en && $urandom_range(0, 3) == 0) begin
                    bus.dp_ready = 1'b1;
                    spur         = 1'b1;
                end
            end
        end
    end

    initial begin
        exp_t            e;
        logic [NREQ-1:0] g_prev;
        bit              chk_idle;
        g_prev = '0; chk_idle = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (chk_idle) begin
                check("busy_after_end", bus.busy, 0);
                chk_idle = 1'b0;
            end
            if (bus.gnt != '0 && g_prev == '0) begin
                if (exp_q.size() == 0) check("gnt_unexpected", bus.gnt, 0);
                else check("gnt_id", bus.gnt, onehot(exp_q[0].id));
            end
            g_prev = bus.gnt;
            if (bus.done != '0 || bus.err != '0) begin
                if (exp_q.size() == 0) begin
                    check("pulse_unexpected", {bus.done, bus.err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_vec", bus.done, e.is_err ? '0 : onehot(e.id));
                    check("err_vec",  bus.err,  e.is_err ? onehot(e.id) : '0);
                    check("result",   bus.result, e.res);
                    check("gnt_clear", bus.gnt, 0);
                    if (e.lat >= 0) check("latency", cyc - t_raise[e.id], e.lat);
                    chk_idle = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        exp_t e;
        int   k;
        bus.req          = '0;
        bus.req_data     = '0;
        bus.req_nadd_sub = '0;
        bus.req_use_prev = '0;
        m_ptr = 0; m_prev = '0; m_last = '0;
        clear_phase();
        #12;
        check_zero("reset");
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Packed add, 1-cycle ack: 3 + 5
        clear_phase(); bfm_delay = 1;
        rem[0] = 1; op_data[0][0] = 32'h0003_0005; op_ns[0][0] = 0; op_up[0][0] = 0;
        run_phase(6);

        // Build prev = 0x25, then requester 1 subtracts 0x10 from it
        clear_phase();
        rem[0] = 1; op_data[0][0] = 32'h0020_0005; op_ns[0][0] = 0; op_up[0][0] = 0;
        run_phase(-1);
        clear_phase();
        rem[1] = 1; op_data[1][0] = 32'h0000_0010; op_ns[1][0] = 1; op_up[1][0] = 1;
        run_phase(-1);

        // Two requesters held high: strict alternation
        clear_phase(); rem[0] = 3; rem[1] = 3;
        run_phase(-1);

        for (int p = 0; p < 8; p++) begin
            clear_phase();
            bfm_delay = $urandom_range(1, 4);
            for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 1) == 1) rem[i] = $urandom_range(1, 3);
            if (!any_rem()) rem[$urandom_range(0, NREQ-1)] = 1;
            run_phase(-1);
        end

        // Ack arriving on the last watchdog cycle still completes normally
        clear_phase(); bfm_delay = TIMEOUT - 1; rem[2] = 1;
        run_phase(-1);

        // No ack at all: abort after TIMEOUT write cycles
        clear_phase(); bfm_delay = NOACK; rem[0] = 1;
        run_phase(TIMEOUT + 1);
        bfm_delay = 1;

        // Async reset during GAP drops the transaction and the pointer
        clear_phase();
        @(negedge wb_clk_i);
        op_data[1][0] = 32'h0004_0001; op_ns[1][0] = 0; op_up[1][0] = 0;
        e.id = 1; e.is_err = 1'b0; e.res = '0; e.lat = -1;
        exp_q.push_back(e);
        present(1);
        k = 0;
        while (!(bus.gnt[1] && !bus.dp_valid && bus.dp_we) && k < 50) begin
            @(negedge wb_clk_i);
            k++;
        end
        check("reach_gap", k < 50, 1);
        #2 wb_rst_i = 1'b1;
        #1 check_zero("async_rst");
        bus.req = '0;
        exp_q.delete();
        @(negedge wb_clk_i);
        check_zero("held_rst");
        wb_rst_i = 1'b0;
        m_ptr = 0;
        clear_phase(); rem[0] = 1; rem[1] = 1; rem[2] = 1;
        run_phase(-1);

        // Requester 0 drops req during WR; the pointer must still advance
        clear_phase(); rem[0] = 1; drop[0] = 1'b1;
        run_phase(-1);
        clear_phase(); rem[0] = 1; rem[1] = 1;
        run_phase(-1);

        repeat (5) @(negedge wb_clk_i);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
